// File: rtl/ysyx_23060332_pkg.sv
// Shared IFU types and constants: state encoding, reset PC, NOP word.
package ysyx_23060332_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h8000_0000;
    localparam logic [XLEN-1:0] INST_NOP     = 32'h0000_0013;

    typedef enum logic [1:0] {
        IFU_IDLE = 2'd0,
        IFU_REQ  = 2'd1,
        IFU_WAIT = 2'd2,
        IFU_HOLD = 2'd3
    } ifu_state_e;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & {{(XLEN-2){1'b1}}, 2'b00};
    endfunction

endpackage

// File: rtl/ysyx_23060332_ifu_if.sv
// IFU bus bundle: imem request/response, instruction output, redirect and halt.
interface ysyx_23060332_ifu_if;
    import ysyx_23060332_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_resp_valid;
    logic [XLEN-1:0] imem_resp_data;
    logic            imem_resp_err;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;
    logic            inst_fault;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            halt;

    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, inst_fault,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
               inst_ready, redirect_valid, redirect_pc, halt
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, inst_fault,
        output imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
               inst_ready, redirect_valid, redirect_pc, halt
    );

endinterface

// File: rtl/ysyx_23060332_pc_gen.sv
// PC register with +4 incrementer and a pending-redirect latch; newest redirect wins.
// pc updates one cycle after a control strobe; no handshake of its own.
module ysyx_23060332_pc_gen
    import ysyx_23060332_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            capture_i,
    input  logic            load_now_i,
    input  logic            apply_i,
    input  logic            incr_i,
    output logic [XLEN-1:0] pc_o,
    output logic            redir_pend_o
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] redir_pc_q, redir_pc_d;
    logic            redir_pend_q, redir_pend_d;
    logic [XLEN-1:0] new_pc;

    assign new_pc = word_align(redirect_pc_i);

    always_comb begin
        pc_d         = pc_q;
        redir_pc_d   = redir_pc_q;
        redir_pend_d = redir_pend_q;
        if (capture_i) begin
            redir_pend_d = 1'b1;
            redir_pc_d   = new_pc;
        end
        // A same-cycle redirect is newer than anything already latched.
        if (apply_i) begin
            pc_d         = capture_i ? new_pc : redir_pc_q;
            redir_pend_d = 1'b0;
        end else if (load_now_i) begin
            pc_d = new_pc;
        end else if (incr_i) begin
            pc_d = pc_q + XLEN'(4);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            redir_pc_q   <= RESET_PC;
            redir_pend_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            redir_pc_q   <= redir_pc_d;
            redir_pend_q <= redir_pend_d;
        end
    end

    assign pc_o         = pc_q;
    assign redir_pend_o = redir_pend_q;

endmodule

// File: rtl/ysyx_23060332_ifu.sv
// Instruction fetch: one outstanding imem request, single-entry output buffer, 3 cycles/inst best case.
// Request held until imem_req_ready; buffer held until inst_ready; redirects drop in-flight work.
module ysyx_23060332_ifu
    import ysyx_23060332_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ysyx_23060332_ifu_if.master  bus
);

    ifu_state_e      state_q, state_d;
    ifu_state_e      run_state;
    logic [XLEN-1:0] pc;
    logic            drop;
    logic            capture, load_now, apply, incr, buf_ld;
    logic [XLEN-1:0] inst_q, inst_pc_q;
    logic            inst_fault_q;

    ysyx_23060332_pc_gen #(.RESET_PC(RESET_PC)) u_pc_gen (
        .clk           (clk),
        .rst_n         (rst_n),
        .redirect_pc_i (bus.redirect_pc),
        .capture_i     (capture),
        .load_now_i    (load_now),
        .apply_i       (apply),
        .incr_i        (incr),
        .pc_o          (pc),
        .redir_pend_o  (drop)
    );

    assign run_state = bus.halt ? IFU_IDLE : IFU_REQ;

    always_comb begin
        state_d  = state_q;
        capture  = 1'b0;
        load_now = 1'b0;
        apply    = 1'b0;
        incr     = 1'b0;
        buf_ld   = 1'b0;
        case (state_q)
            IFU_IDLE: begin
                load_now = bus.redirect_valid;
                if (!bus.halt) state_d = IFU_REQ;
            end
            IFU_REQ: begin
                // Request stays up with its original address; redirect waits in pc_gen.
                capture = bus.redirect_valid;
                if (bus.imem_req_ready) state_d = IFU_WAIT;
            end
            IFU_WAIT: begin
                capture = bus.redirect_valid;
                if (bus.imem_resp_valid) begin
                    if (drop || bus.redirect_valid) begin
                        apply   = 1'b1;
                        state_d = run_state;
                    end else begin
                        buf_ld  = 1'b1;
                        incr    = 1'b1;
                        state_d = IFU_HOLD;
                    end
                end
            end
            IFU_HOLD: begin
                if (bus.redirect_valid) begin
                    load_now = 1'b1;
                    state_d  = run_state;
                end else if (bus.inst_ready) begin
                    state_d = run_state;
                end
            end
            default: state_d = IFU_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IFU_IDLE;
            inst_q       <= INST_NOP;
            inst_pc_q    <= RESET_PC;
            inst_fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (buf_ld) begin
                inst_q       <= bus.imem_resp_data;
                inst_pc_q    <= pc;
                inst_fault_q <= bus.imem_resp_err;
            end
        end
    end

    assign bus.imem_req_valid = (state_q == IFU_REQ);
    assign bus.imem_req_addr  = pc;
    assign bus.inst_valid     = (state_q == IFU_HOLD);
    assign bus.inst           = inst_q;
    assign bus.inst_pc        = inst_pc_q;
    assign bus.inst_fault     = inst_fault_q;

endmodule

// File: doc/ysyx_23060332_ifu.md
# ysyx_23060332_ifu

Instruction fetch unit for the single-issue NPC core. Holds the PC and issues one fetch at a time to instruction memory over a valid/ready request and valid-only response. It buffers the returned word and presents it with its PC to the decode/execute stage (the ALU consumes `inst`). Control-flow redirects from downstream cancel or replace in-flight work.

## Interface
- `RESET_PC`, default 32'h8000_0000: PC loaded at reset.
- `clk`  in  1  core clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts request this cycle.
- `imem_req_addr`  out  32  fetch address; word-aligned.
- `imem_resp_valid`  in  1  response word valid (one per accepted request, ≥1 cycle after acceptance).
- `imem_resp_data`  in  32  fetched instruction.
- `imem_resp_err`  in  1  access fault for this response.
- `inst_valid`  out  1  buffered instruction valid.
- `inst_ready`  in  1  downstream consumes instruction.
- `inst`  out  32  instruction word.
- `inst_pc`  out  32  PC of `inst`.
- `inst_fault`  out  1  instruction came back with `imem_resp_err`.
- `redirect_valid`  in  1  one-cycle pulse: replace PC.
- `redirect_pc`  in  32  new PC; bits [1:0] ignored (forced 0).
- `halt`  in  1  level: stop issuing new fetches.

## Operation
- FSM states: IDLE, REQ, WAIT, HOLD. Reset state IDLE.
- IDLE: no request. Go to REQ when `halt`=0.
- REQ: `imem_req_valid`=1, `imem_req_addr`=pc. Address and valid stay stable until `imem_req_ready`. On handshake, go to WAIT.
- WAIT: on `imem_resp_valid` with `drop`=0:
  - latch `inst` ← data, `inst_fault` ← err, `inst_pc` ← pc;
  - pc ← pc+4 (mod 2^32, wraps at 32'hFFFF_FFFC→0);
  - go to HOLD.
- HOLD: `inst_valid`=1, outputs stable. On `inst_ready`, go to IDLE if `halt`=1, else REQ.
- Faults do not stop fetch. pc still advances by 4; downstream decides what to do.
- Redirect handling: the newest redirect wins. It is held in `redir_pend`/`redir_pc` until applied.
  - IDLE: pc ← redirect_pc immediately.
  - REQ, no handshake this cycle: the request is not retracted. Set `redir_pend`. On handshake go to WAIT with `drop`=1.
  - REQ with handshake the same cycle: go to WAIT with `drop`=1 and the new PC pending.
  - WAIT: set `drop`=1 and update the pending PC. A response arriving the same cycle as the redirect is discarded.
  - WAIT with `drop`=1 when the response arrives: discard it (no HOLD); pc ← redir_pc; clear `drop`/`redir_pend`; go to REQ (or IDLE if `halt`).
  - HOLD: if `inst_ready` is also high, the handshake completes; otherwise the buffer is killed. Either way pc ← redirect_pc, `inst_valid` drops next cycle, and the FSM goes to REQ (or IDLE if `halt`).
- `halt` never aborts an accepted request. The response is still collected and presented.

## Timing
- Reset values: `imem_req_valid`=0, `imem_req_addr`=RESET_PC, `inst_valid`=0, `inst`=32'h0000_0013 (nop), `inst_pc`=RESET_PC, `inst_fault`=0; `drop`/`redir_pend`=0.
- Reset is asynchronous. Asserted mid-transaction, it clears everything. A response arriving after reset release with no accepted request is ignored.
- First request: `imem_req_valid` goes high in the 2nd cycle after `rst_n` deasserts (IDLE→REQ).
- Best-case throughput is one instruction per 3 cycles with zero-wait memory: REQ, WAIT with response, HOLD with ready.
- `inst_valid` rises the cycle after the accepted response.
- Redirect-to-request latency: 1 cycle from IDLE/HOLD. From WAIT, 1 cycle after the discarded response.
- All outputs are registered or decoded from state only. There is no combinational path from `inst_ready`/`redirect_valid` to `imem_req_*`.

## Structure
- Shared package `ysyx_23060332_pkg`:
  - IFU state encoding (2-bit enum);
  - `RESET_PC` default;
  - `INST_NOP` = 32'h0000_0013;
  - XLEN = 32.
- One sub-module, `ysyx_23060332_pc_gen`: pc register, +4 incrementer, `redir_pend`/`redir_pc` latch, and next-pc select. The FSM and output buffer stay in the top module.

## Test plan
- Reset release, memory always ready, 1-cycle response, `inst_ready`=1 → addresses 8000_0000, 8000_0004, 8000_0008 in order; `inst_pc` matches each; one instruction per 3 cycles.
- `imem_req_ready` held low 5 cycles → `imem_req_addr`/valid stable throughout; exactly one request accepted.
- Redirect to 8000_0100 while in WAIT, response returns 2 cycles later → response discarded, `inst_valid` stays 0, next request addr 8000_0100.
- Redirect and response in the same cycle → response dropped; next fetch at the redirect PC.
- `inst_ready`=0 for 4 cycles in HOLD → `inst`/`inst_pc` stable, no new request.
- Redirect in HOLD → `inst_valid` falls the next cycle, then request at the new PC.
- `imem_resp_err`=1 at 8000_0008 → `inst_fault`=1 with `inst_pc`=8000_0008; next fetch at 8000_000C with `inst_fault`=0.
- `rst_n` pulsed low in WAIT → outputs return to reset values asynchronously; first request after release at RESET_PC.
